// File: rtl/ttltx_pkg.sv
// ttltx_pkg: shared TTL serial link constants and transmitter state codes
package ttltx_pkg;
    localparam int DEF_CLKS_PER_BIT = 54;
    localparam int DEF_HALF_BIT     = 27;
    localparam int DATA_W           = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} tx_state_t;
endpackage

// File: rtl/ttltx_fifo.sv
// ttltx_fifo: DEPTH x 8 synchronous FIFO with registered not-full ready
//   push/pop/wdata in; rdata, empty, ready, count out; rst_n async active-low
module ttltx_fifo
    import ttltx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic                     empty,
    output logic                     ready,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count_next;
    assign count_next = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    assign rdata      = mem[rd_ptr];
    assign empty      = count == '0;
    // ready is held low through reset and rises on the first edge after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            ready <= count_next != (PW+1)'(DEPTH);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/ttltx.sv
// ttltx: 8N1/8N2 UART transmitter, LSB first, idle-high, fed by a small FIFO
//   in_byte/in_byte_valid/in_ready: producer handshake; txpin: registered line
//   tx_busy: frame on line or bytes queued; fifo_count: queued bytes
module ttltx
    import ttltx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    in_byte,
    input  logic                          in_byte_valid,
    output logic                          in_ready,
    output logic                          txpin,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(CLKS_PER_BIT - 1);
    localparam logic [SW-1:0] STOP_MAX = SW'(STOP_BITS - 1);
    tx_state_t         state_q, state_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [2:0]        bit_q, bit_d;
    logic [SW-1:0]     stop_q, stop_d;
    logic [DATA_W-1:0] shreg_q, shreg_d, rdata;
    logic              tx_d, pop, empty, bit_end;
    ttltx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_byte_valid & in_ready),
        .pop   (pop),
        .wdata (in_byte),
        .rdata (rdata),
        .empty (empty),
        .ready (in_ready),
        .count (fifo_count)
    );
    assign bit_end = tick_q == TICK_MAX;
    assign tx_busy = (state_q != IDLE) | (fifo_count != '0);
    // the shift register is pre-shifted as each bit is launched, so shreg_q[0] is always the next bit
    always_comb begin
        state_d = state_q;
        tick_d  = bit_end ? '0 : tick_q + 1'b1;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shreg_d = shreg_q;
        tx_d    = txpin;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                tick_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_d = rdata;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: if (bit_end) begin
                tx_d    = shreg_q[0];
                shreg_d = shreg_q >> 1;
                bit_d   = '0;
                state_d = DATA;
            end
            DATA: if (bit_end) begin
                if (bit_q == 3'd7) begin
                    tx_d    = 1'b1;
                    stop_d  = '0;
                    state_d = STOP;
                end else begin
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    bit_d   = bit_q + 1'b1;
                end
            end
            STOP: if (bit_end) begin
                if (stop_q != STOP_MAX) stop_d = stop_q + 1'b1;
                else if (!empty) begin
                    pop     = 1'b1;
                    shreg_d = rdata;
                    tx_d    = 1'b0;
                    state_d = START;
                end else state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            stop_q  <= '0;
            shreg_q <= '0;
            txpin   <= 1'b1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shreg_q <= shreg_d;
            txpin   <= tx_d;
        end
    end
endmodule
